// File: rtl/branch_pkg.sv
// Shared constants and types for the branch resolution unit and its history table.
package branch_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam int unsigned PERF_W = 32;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } func3_e;

    // 2-bit saturating counter states; MSB is the taken prediction.
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Flag half of the output register; the XLEN-wide PCs sit beside it.
    typedef struct packed {
        logic is_branch;
        logic illegal;
        logic taken;
        logic mispredict;
    } result_t;

endpackage

// File: rtl/branch_unit_if.sv
// Request/response and fetch-prediction signals between decode, branch_unit and fetch.
interface branch_unit_if #(parameter int unsigned XLEN = 32);

    logic            in_valid;
    logic            in_ready;
    logic [6:0]      in_opcode;
    logic [2:0]      in_func3;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic [XLEN-1:0] in_imm;
    logic            in_pred_taken;
    logic [XLEN-1:0] fetch_pc;
    logic            fetch_pred_taken;
    logic            out_valid;
    logic            out_ready;
    logic            out_is_branch;
    logic            out_illegal;
    logic            out_taken;
    logic [XLEN-1:0] out_target;
    logic [XLEN-1:0] out_redirect_pc;
    logic            out_mispredict;

    modport master (
        output in_valid, in_opcode, in_func3, in_pc, in_rs1, in_rs2, in_imm,
               in_pred_taken, fetch_pc, out_ready,
        input  in_ready, fetch_pred_taken, out_valid, out_is_branch, out_illegal,
               out_taken, out_target, out_redirect_pc, out_mispredict
    );

    modport slave (
        input  in_valid, in_opcode, in_func3, in_pc, in_rs1, in_rs2, in_imm,
               in_pred_taken, fetch_pc, out_ready,
        output in_ready, fetch_pred_taken, out_valid, out_is_branch, out_illegal,
               out_taken, out_target, out_redirect_pc, out_mispredict
    );

endinterface

// File: rtl/branch_bht.sv
// Branch history table: array of 2-bit saturating counters, async read, one update per cycle.
module branch_bht
    import branch_pkg::*;
#(
    parameter int unsigned BHT_ENTRIES = 64,
    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [1:0]       rd_ctr_o,
    input  logic             we_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic             wr_taken_i
);

    logic [1:0] ctr_q [BHT_ENTRIES];
    logic [1:0] ctr_d;

    // Saturating step of the entry being trained.
    always_comb begin
        ctr_d = ctr_q[wr_idx_i];
        if (wr_taken_i && ctr_q[wr_idx_i] != ST) begin
            ctr_d = ctr_q[wr_idx_i] + 2'd1;
        end else if (!wr_taken_i && ctr_q[wr_idx_i] != SNT) begin
            ctr_d = ctr_q[wr_idx_i] - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
                ctr_q[i] <= WNT;
            end
        end else if (we_i) begin
            ctr_q[wr_idx_i] <= ctr_d;
        end
    end

    // No write-to-read bypass: fetch sees the pre-update counter.
    assign rd_ctr_o = ctr_q[rd_idx_i];

endmodule

// File: rtl/branch_unit.sv
// Conditional branch resolution with target/redirect generation and BHT training.
// Optional perf counters are built when BRANCH_PERF_EN is defined.
module branch_unit
    import branch_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BHT_ENTRIES = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    branch_unit_if.slave       bus
`ifdef BRANCH_PERF_EN
    ,
    output logic [PERF_W-1:0]  perf_branches,
    output logic [PERF_W-1:0]  perf_mispredicts
`endif
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    logic            is_op;
    logic            eq;
    logic            lt_s;
    logic            lt_u;
    logic            cond_taken;
    logic            legal_f3;
    logic            accept;
    result_t         res_d;
    result_t         res_q;
    logic [XLEN-1:0] target_d;
    logic [XLEN-1:0] redirect_d;
    logic [XLEN-1:0] target_q;
    logic [XLEN-1:0] redirect_q;
    logic            valid_q;
    logic [1:0]      rd_ctr;
    logic            unused_fetch_bits;

    assign is_op = (bus.in_opcode == OP_BRANCH);
    assign eq    = (bus.in_rs1 == bus.in_rs2);
    assign lt_s  = ($signed(bus.in_rs1) < $signed(bus.in_rs2));
    assign lt_u  = (bus.in_rs1 < bus.in_rs2);

    // Condition select and result flags for the presented instruction.
    always_comb begin
        cond_taken = 1'b0;
        legal_f3   = 1'b1;
        case (func3_e'(bus.in_func3))
            BEQ:     cond_taken = eq;
            BNE:     cond_taken = !eq;
            BLT:     cond_taken = lt_s;
            BGE:     cond_taken = !lt_s;
            BLTU:    cond_taken = lt_u;
            BGEU:    cond_taken = !lt_u;
            default: legal_f3   = 1'b0;
        endcase
        res_d            = '0;
        res_d.is_branch  = is_op && legal_f3;
        res_d.illegal    = is_op && !legal_f3;
        res_d.taken      = res_d.is_branch && cond_taken;
        res_d.mispredict = (res_d.taken != bus.in_pred_taken);
    end

    assign target_d   = bus.in_pc + bus.in_imm;
    assign redirect_d = res_d.taken ? target_d : (bus.in_pc + XLEN'(4));

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            res_q      <= '0;
            target_q   <= '0;
            redirect_q <= '0;
        end else if (accept) begin
            valid_q    <= 1'b1;
            res_q      <= res_d;
            target_q   <= target_d;
            redirect_q <= redirect_d;
        end else if (bus.out_ready) begin
            valid_q    <= 1'b0;
        end
    end

    assign bus.out_valid       = valid_q;
    assign bus.out_is_branch   = res_q.is_branch;
    assign bus.out_illegal     = res_q.illegal;
    assign bus.out_taken       = res_q.taken;
    assign bus.out_mispredict  = res_q.mispredict;
    assign bus.out_target      = target_q;
    assign bus.out_redirect_pc = redirect_q;

    branch_bht #(.BHT_ENTRIES(BHT_ENTRIES)) u_bht (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_idx_i   (bus.fetch_pc[IDX_W+1:2]),
        .rd_ctr_o   (rd_ctr),
        .we_i       (accept && res_d.is_branch),
        .wr_idx_i   (bus.in_pc[IDX_W+1:2]),
        .wr_taken_i (res_d.taken)
    );

    assign bus.fetch_pred_taken = rd_ctr[1];
    assign unused_fetch_bits    = ^{bus.fetch_pc[XLEN-1:IDX_W+2], bus.fetch_pc[1:0], rd_ctr[0]};

`ifdef BRANCH_PERF_EN
    logic [PERF_W-1:0] perf_br_q;
    logic [PERF_W-1:0] perf_mis_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_br_q  <= '0;
            perf_mis_q <= '0;
        end else if (accept) begin
            if (res_d.is_branch)  perf_br_q  <= perf_br_q + PERF_W'(1);
            if (res_d.mispredict) perf_mis_q <= perf_mis_q + PERF_W'(1);
        end
    end

    assign perf_branches    = perf_br_q;
    assign perf_mispredicts = perf_mis_q;
`endif

endmodule
